paso8bto32b: RTL
================

Name: paso8bto32b

Overview:
- Byte-to-word deserializer; receive-side counterpart of the 32b-to-8b serializer.
- Takes a qualified byte stream on the fast clock clk_4f and rebuilds 32-bit words, MSB byte first.
- Emits each word with a one-cycle valid pulse.
- Flags frames that end before all bytes arrive.
- Sits at the receive end of the byte lane, feeding the word-domain logic.

Parameters:
- WORD_BYTES, 4, bytes per output word; word width = 8*WORD_BYTES. Only 4 is required; keep it generic.
- CNT_W, 2, byte-counter width = clog2(WORD_BYTES).

Ports:
- clk_4f  input  1  single clock, byte rate; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  byte from the serial lane.
- valid_in  input  1  data_in is valid this cycle.
- data_out  output  32  assembled word; first received byte in [31:24].
- valid_out  output  1  one-cycle pulse: data_out holds a new complete word.
- frame_err  output  1  one-cycle pulse: a partial word was aborted.
- busy  output  1  high while a word is partially collected.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, valid_out=0, frame_err=0, busy=0, byte counter=0, shift register=0, state=IDLE.
  - Release is synchronous to clk_4f.
- State machine: IDLE, COLLECT.
- IDLE:
  - valid_in=1: load byte into shift register, counter=1, go to COLLECT.
  - valid_in=0: stay in IDLE.
- COLLECT, valid_in=1:
  - Shift in byte (shreg <= {shreg[23:0], data_in}), counter+1.
  - If this is byte WORD_BYTES (counter was WORD_BYTES-1):
    - On this edge, register the completed word into data_out and assert valid_out for the next cycle.
    - counter wraps to 0; go to IDLE.
- COLLECT, valid_in=0 (partial word):
  - Assert frame_err for one cycle, discard the partial word, counter=0, go to IDLE.
  - data_out keeps its previous value; valid_out=0.
- Latency: valid_out and data_out update on the same edge that samples the 4th byte, so they are visible during the following cycle.
- valid_out is high exactly one cycle per word and is never asserted together with frame_err.
- Back-to-back words: valid_in held high for 8 cycles gives two words.
  - valid_out pulses after byte 4 and after byte 8.
  - No gap cycle is required; byte 5 is accepted in the cycle after the wrap, i.e. IDLE with valid_in=1.
- data_out holds between words; it changes only on a completed word or on reset.
- busy = (state==COLLECT).
- data_in is don't-care when valid_in=0; it must never enter the shift register.
- Reset asserted mid-word: partial data is discarded immediately, with no frame_err and no valid_out.
- Counter arithmetic is modulo WORD_BYTES. The counter never exceeds WORD_BYTES-1.

Decomposition:
- Shared package/header holds:
  - BYTE_W=8, WORD_BYTES=4, WORD_W=32
  - state encodings ST_IDLE=1'b0, ST_COLLECT=1'b1
- These are shared with the 32b-to-8b serializer, so byte order and widths stay consistent across both ends.
- One natural sub-module, paso8bto32b_cnt: the modulo-WORD_BYTES byte counter with a wrap (last_byte) output. The FSM, shift register and output registers stay in the top module.
- A synthesized copy is compared against behavioural RTL in the bench, as on the serializer side.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid_in=1 and data_in=8'hAA -> all outputs 0, busy=0; no valid_out after release until 4 new valid bytes.
- Single word: bytes AB, CD, EF, FF on 4 consecutive cycles with valid_in=1 -> one-cycle valid_out with data_out=32'hABCDEFFF; frame_err=0; busy low afterwards.
- Back-to-back: 8 consecutive bytes AB CD EF FF AD BD CD DD -> valid_out pulses exactly 4 cycles apart, with data_out=32'hABCDEFFF then 32'hADBDCDDD.
- Abort: bytes 01, 02, then valid_in=0 -> frame_err pulse 1 cycle, no valid_out, data_out unchanged (32'hADBDCDDD). Then 01 02 04 03 -> data_out=32'h01020403.
- Idle gaps: valid_in=0 for 5 cycles with data_in toggling random values -> no output change, busy=0, frame_err=0.
- Reset mid-word: after bytes 11, 22 assert reset -> data_out=0, no frame_err. After release, 44 33 22 11 -> data_out=32'h44332211.
- Equivalence: every scenario above must give data_out and valid_out identical to the synthesized netlist, cycle by cycle.

Source files
------------

// File: rtl/paso8bto32b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paso8bto32b_pkg
// Description : Widths and state encodings shared by both ends of the byte lane.
// Revision    : 1.0 - initial release
// ============================================================================
package paso8bto32b_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage : paso8bto32b_pkg
`default_nettype wire

// File: rtl/paso8bto32b_cnt.sv
`default_nettype none
// ============================================================================
// Module      : paso8bto32b_cnt
// Description : Modulo-WORD_BYTES byte counter with last-byte flag.
// Revision    : 1.0 - initial release
// ============================================================================
module paso8bto32b_cnt #(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = $clog2(WORD_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last_byte
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORD_BYTES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_cnt       = cnt_q;
    assign o_last_byte = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = o_last_byte ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : paso8bto32b_cnt
`default_nettype wire

// File: rtl/paso8bto32b.sv
`default_nettype none
// ============================================================================
// Module      : paso8bto32b
// Description : Byte-to-word deserializer, MSB byte first, with abort flag.
// Revision    : 1.0 - initial release
// ============================================================================
module paso8bto32b #(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = $clog2(WORD_BYTES)
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic [8*WORD_BYTES-1:0]       data_out,
    output logic                          valid_out,
    output logic                          frame_err,
    output logic                          busy
);

    import paso8bto32b_pkg::*;

    localparam int C_WORD_W = BYTE_W * WORD_BYTES;

    state_t                state_q;
    state_t                state_d;
    logic [C_WORD_W-1:0]   shreg_q;
    logic [C_WORD_W-1:0]   shreg_d;
    logic [C_WORD_W-1:0]   data_out_q;
    logic [C_WORD_W-1:0]   data_out_d;
    logic                  valid_out_q;
    logic                  valid_out_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    logic                  w_cnt_inc;
    logic                  w_cnt_clr;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_last_byte;
    logic [C_WORD_W-1:0]   w_shifted;

    paso8bto32b_cnt #(
        .WORD_BYTES (WORD_BYTES),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk         (clk_4f),
        .rst_n       (reset),
        .i_clr       (w_cnt_clr),
        .i_inc       (w_cnt_inc),
        .o_cnt       (w_cnt),
        .o_last_byte (w_last_byte)
    );

    assign w_shifted = {shreg_q[C_WORD_W-BYTE_W-1:0], data_in};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        frame_err_d = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    shreg_d   = {{(C_WORD_W-BYTE_W){1'b0}}, data_in};
                    w_cnt_inc = 1'b1;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (valid_in) begin
                    shreg_d   = w_shifted;
                    w_cnt_inc = 1'b1;
                    if (w_last_byte) begin
                        data_out_d  = w_shifted;
                        valid_out_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    // Lane went quiet mid-word: drop the partial word.
                    shreg_d     = '0;
                    frame_err_d = 1'b1;
                    w_cnt_clr   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_COLLECT);

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule : paso8bto32b
`default_nettype wire
